// File: rtl/prog_loader.sv
// Boot loader: packs a byte stream little-endian into 32-bit memory writes and holds the core in reset until done.
// Optional PROG_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte that must zero the running sum.
//
// state     | meaning
// S_LOAD    | accept image bytes, pack lanes, issue word writes
// S_CHECK   | (checksum build) accept one checksum byte and verify it
// S_FLUSH   | final write retiring
// S_RELEASE | last cycle with core held in reset
// S_RUN     | core released, done asserted, terminal
// S_ERR     | overflow or bad checksum, core held, terminal
module prog_loader #(
    parameter int ADDR_W     = 16,
    parameter int MEM_BYTES  = 65536,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_LOAD,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_FLUSH,
        S_RELEASE,
        S_RUN,
        S_ERR
    } state_t;

    // One extra address bit so the wrap past 2^ADDR_W still reads as overflow.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

    state_t              state_q, state_d;
    logic [1:0]          lane_q, lane_d;
    logic [31:0]         buf_q, buf_d;
    logic [ADDR_W:0]     wr_addr_q, wr_addr_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_wstrb_q, mem_wstrb_d;
    logic                core_rst_q, core_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                hs;
    logic [31:0]         word_v;
    logic [3:0]          fill_mask;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
    logic [7:0]          sum_chk;
`endif

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        buf_d       = buf_q;
        wr_addr_d   = wr_addr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = 4'b0000;
        hs          = in_valid && in_ready_q;
        word_v      = buf_q;
        word_v[{lane_q, 3'b000} +: 8] = in_data;
        case (lane_q)
            2'd0:    fill_mask = 4'b0001;
            2'd1:    fill_mask = 4'b0011;
            2'd2:    fill_mask = 4'b0111;
            default: fill_mask = 4'b1111;
        endcase
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        sum_chk = sum_q + in_data;
`endif

        case (state_q)
            S_LOAD: begin
                if (hs) begin
                    if (wr_addr_q >= LIMIT) begin
                        state_d = S_ERR;
                    end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_d = sum_chk;
`endif
                        if (lane_q == 2'd3 || in_last) begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = wr_addr_q[ADDR_W-1:0];
                            mem_wdata_d = word_v;
                            mem_wstrb_d = fill_mask;
                            lane_d      = 2'd0;
                            buf_d       = 32'h0;
                            wr_addr_d   = wr_addr_q + (ADDR_W+1)'(4);
                        end else begin
                            lane_d = lane_q + 2'd1;
                            buf_d  = word_v;
                        end
                        if (in_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_d = S_CHECK;
`else
                            state_d = S_FLUSH;
`endif
                        end
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (hs) state_d = (sum_chk == 8'h00) ? S_FLUSH : S_ERR;
            end
`endif
            S_FLUSH:   state_d = S_RELEASE;
            S_RELEASE: state_d = S_RUN;
            S_RUN:     state_d = S_RUN;
            default:   state_d = S_ERR;
        endcase

`ifdef PROG_LOADER_CHECKSUM_EN
        in_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
`else
        in_ready_d = (state_d == S_LOAD);
`endif
        core_rst_d = (state_d != S_RUN);
        done_d     = (state_d == S_RUN);
        err_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_LOAD;
            lane_q      <= 2'd0;
            buf_q       <= 32'h0;
            wr_addr_q   <= (ADDR_W+1)'(START_ADDR);
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= ADDR_W'(START_ADDR);
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            buf_q       <= buf_d;
            wr_addr_q   <= wr_addr_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            core_rst_q  <= core_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign core_rst  = core_rst_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: default-size instance plus an 8-byte-memory instance for overflow.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        sel = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;

    logic        in_ready_a, mem_we_a, core_rst_a, done_a, err_a;
    logic [15:0] mem_addr_a;
    logic [31:0] mem_wdata_a;
    logic [3:0]  mem_wstrb_a;
    logic        in_ready_b, mem_we_b, core_rst_b, done_b, err_b;
    logic [15:0] mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [3:0]  mem_wstrb_b;
    logic        valid_a, valid_b;

    int checks = 0;
    int errors = 0;
    logic [51:0] wq_a[$];
    logic [51:0] wq_b[$];
    logic [7:0]  img[0:15];
    logic [7:0]  sum;

    assign valid_a = in_valid && !sel;
    assign valid_b = in_valid && sel;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk(clk), .rst(rst), .in_valid(valid_a), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_wstrb(mem_wstrb_a),
        .core_rst(core_rst_a), .done(done_a), .err(err_a)
    );

    prog_loader #(.ADDR_W(16), .MEM_BYTES(8), .START_ADDR(0)) dut_s (
        .clk(clk), .rst(rst), .in_valid(valid_b), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_wstrb(mem_wstrb_b),
        .core_rst(core_rst_b), .done(done_b), .err(err_b)
    );

    always @(negedge clk) begin
        if (mem_we_a) wq_a.push_back({mem_addr_a, mem_wdata_a, mem_wstrb_a});
        if (mem_we_b) wq_b.push_back({mem_addr_b, mem_wdata_b, mem_wstrb_b});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        #2;
        chk("rst_in_ready", in_ready_a, 0);
        chk("rst_mem_we", mem_we_a, 0);
        chk("rst_mem_addr", mem_addr_a, 0);
        chk("rst_mem_wdata", mem_wdata_a, 0);
        chk("rst_mem_wstrb", mem_wstrb_a, 0);
        chk("rst_core_rst", core_rst_a, 1);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        @(negedge clk);
        rst = 1'b1;
        wq_a.delete();
        wq_b.delete();
        @(negedge clk);
        chk("post_rst_in_ready", in_ready_a, 1);
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends img[0..n-1] with last on the final byte, plus the zeroing checksum when that build is active.
    task automatic send_img(input int n);
        sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            send(img[i], i == n - 1);
            sum = sum + img[i];
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send(8'h00 - sum, 1'b0);
`endif
    endtask

    initial begin
        // Test 1: two full words back-to-back, release timing.
        do_reset();
        img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'h00; img[3] = 8'h00;
        img[4] = 8'h93; img[5] = 8'h05; img[6] = 8'h10; img[7] = 8'h00;
        send(img[0], 0); send(img[1], 0);
        chk("t1_ready_mid", in_ready_a, 1);
        sum = img[0] + img[1];
        for (int i = 2; i < 7; i++) begin
            send(img[i], 0);
            sum = sum + img[i];
        end
        send(img[7], 1);
`ifdef PROG_LOADER_CHECKSUM_EN
        sum = sum + img[7];
        send(8'h00 - sum, 0);
        @(negedge clk);
`else
        @(negedge clk);
        chk("t1_we_n1", mem_we_a, 1);
`endif
        chk("t1_core_rst_n1", core_rst_a, 1);
        @(negedge clk);
        chk("t1_core_rst_n2", core_rst_a, 1);
        chk("t1_done_n2", done_a, 0);
        @(negedge clk);
        chk("t1_core_rst_n3", core_rst_a, 0);
        chk("t1_done_n3", done_a, 1);
        chk("t1_ready_run", in_ready_a, 0);
        chk("t1_nwr", wq_a.size(), 2);
        chk("t1_wr0", wq_a[0], {16'h0000, 32'h00000513, 4'hF});
        chk("t1_wr1", wq_a[1], {16'h0004, 32'h00100593, 4'hF});

        // Test 2: partial final word.
        do_reset();
        for (int i = 0; i < 6; i++) img[i] = 8'(i + 1);
        send_img(6);
        repeat (4) @(negedge clk);
        chk("t2_nwr", wq_a.size(), 2);
        chk("t2_wr0", wq_a[0], {16'h0000, 32'h04030201, 4'hF});
        chk("t2_wr1", wq_a[1], {16'h0004, 32'h00000605, 4'h3});
        chk("t2_done", done_a, 1);

        // Test 3: valid toggling every other cycle.
        do_reset();
        img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'h00; img[3] = 8'h00;
        send(img[0], 0); @(negedge clk);
        send(img[1], 0); @(negedge clk);
        send(img[2], 0); @(negedge clk);
        repeat (2) @(negedge clk);
        chk("t3_idle_nwr", wq_a.size(), 0);
        send(img[3], 1);
`ifdef PROG_LOADER_CHECKSUM_EN
        @(negedge clk);
        send(8'hE8, 0);
`endif
        repeat (6) @(negedge clk);
        chk("t3_nwr", wq_a.size(), 1);
        chk("t3_wr0", wq_a[0], {16'h0000, 32'h00000513, 4'hF});
        chk("t3_done", done_a, 1);

        // Test 4: overflow on the 8-byte memory instance.
        do_reset();
        sel = 1'b1;
        for (int i = 1; i <= 8; i++) send(8'(i), 0);
        send(8'h09, 1);
        chk("t4_err", err_b, 1);
        chk("t4_core_rst", core_rst_b, 1);
        chk("t4_ready", in_ready_b, 0);
        repeat (4) @(negedge clk);
        chk("t4_done", done_b, 0);
        chk("t4_core_rst_hold", core_rst_b, 1);
        chk("t4_nwr", wq_b.size(), 2);
        chk("t4_wr0", wq_b[0], {16'h0000, 32'h04030201, 4'hF});
        chk("t4_wr1", wq_b[1], {16'h0004, 32'h08070605, 4'hF});
        chk("t4_a_quiet", wq_a.size(), 0);
        sel = 1'b0;

        // Test 5: async reset mid-load discards the partial word.
        do_reset();
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_core_rst_async", core_rst_a, 1);
        chk("t5_ready_async", in_ready_a, 0);
        @(negedge clk);
        rst = 1'b1;
        img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC; img[3] = 8'hDD;
        send_img(4);
        repeat (4) @(negedge clk);
        chk("t5_nwr", wq_a.size(), 1);
        chk("t5_wr0", wq_a[0], {16'h0000, 32'hDDCCBBAA, 4'hF});
        chk("t5_done", done_a, 1);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Test 6: checksum accept and reject.
        do_reset();
        send(8'h01, 0); send(8'h02, 1); send(8'hFD, 0);
        repeat (3) @(negedge clk);
        chk("t6_done", done_a, 1);
        chk("t6_err", err_a, 0);
        chk("t6_nwr", wq_a.size(), 1);
        do_reset();
        send(8'h01, 0); send(8'h02, 1); send(8'h00, 0);
        repeat (3) @(negedge clk);
        chk("t6b_err", err_a, 1);
        chk("t6b_core_rst", core_rst_a, 1);
        chk("t6b_done", done_a, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting directly upstream of the core and its unified memory. It streams a program image byte-by-byte over a valid/ready interface, packs the bytes little-endian into 32-bit words, writes them into core memory from `START_ADDR` upward, and holds the core in reset until the image is fully written. On completion it releases the core; on overflow it parks in an error state with the core still held in reset.

## Interface
Parameters:
- `ADDR_W`, 16, byte-address width of core memory.
- `MEM_BYTES`, 65536, memory size in bytes; writes at or beyond this are overflow.
- `START_ADDR`, 0, byte address of the first image word; must be 4-byte aligned.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream byte valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `in_data`  in  8  image byte.
- `in_last`  in  1  qualifies the final image byte.
- `mem_we`  out  1  one-cycle memory write strobe.
- `mem_addr`  out  ADDR_W  word-aligned byte address (bits [1:0] = 0).
- `mem_wdata`  out  32  packed little-endian word.
- `mem_wstrb`  out  4  byte-lane enables; bit i covers `mem_wdata[8i+7:8i]`.
- `core_rst`  out  1  active-high reset to the core.
- `done`  out  1  image loaded, core released (sticky).
- `err`  out  1  overflow or checksum failure (sticky).

## Operation
- A byte handshake occurs when `in_valid && in_ready`.
- States: LOAD, FLUSH, RELEASE, RUN, ERR. Reset enters LOAD.
- LOAD:
  - `in_ready=1`.
  - Each handshake stores `in_data` into lane `lane` of the word buffer, then increments `lane` (2-bit counter).
  - When lane 3 is filled, or on `in_last`, a write of the buffered lanes is issued at `wr_addr`, with `mem_wstrb` set for the filled lanes only (e.g. 2 bytes then last -> `4'b0011`). Lane and buffer are then cleared, and `wr_addr += 4`.
  - `in_last` -> FLUSH.
- Overflow: if a handshake would fill a lane at `wr_addr >= MEM_BYTES`, the byte is dropped, no write is issued, and the state goes to ERR.
- FLUSH: waits one cycle for the final write to retire. If no bytes were received (`in_last` never asserted with data), nothing is written. Then goes to RELEASE.
- RELEASE: `core_rst` is still 1 for exactly one cycle. Next state is RUN.
- RUN: `core_rst=0`, `done=1`, `in_ready=0`. Terminal until reset.
- ERR: `err=1`, `core_rst=1`, `in_ready=0`. Terminal until reset.
- `wr_addr` is `ADDR_W` bits wide. Compare it against `MEM_BYTES` with one extra bit so that the wrap at `2^ADDR_W` is detected as overflow, never written.

## Timing
- Reset values: `in_ready=0` while `rst` is low, 1 from the first cycle after release. `mem_we=0`, `mem_addr=START_ADDR`, `mem_wdata=0`, `mem_wstrb=0`, `core_rst=1`, `done=0`, `err=0`.
- Write latency: `mem_we` and its address/data/strobe are registered and appear the cycle after the completing handshake, for exactly one cycle.
- Back-to-back bytes at one per cycle are sustained; `in_ready` never drops during LOAD.
- Last-byte handshake at cycle N:
  - write at N+1;
  - FLUSH at N+1;
  - RELEASE at N+2;
  - `core_rst` falls and `done` rises at N+3.
- `in_valid` without `in_ready`: `in_data` and `in_last` are ignored.
- `rst` asserted mid-load: all state is cleared asynchronously. `core_rst` returns to 1 immediately. Partial words are discarded with no write.

## Configuration
- Macro `PROG_LOADER_CHECKSUM_EN`.
- Defined:
  - An 8-bit running sum (mod 256) of all image bytes is kept.
  - After the `in_last` byte, the loader stays in a CHECK state with `in_ready=1` and accepts exactly one checksum byte, which is not written to memory.
  - If (sum + checksum byte) mod 256 == 0, go to FLUSH; otherwise go to ERR.
  - The last data write timing is unchanged.
- Undefined: no CHECK state and no sum register; `in_last` goes directly to FLUSH.

## Test plan
- Stream 8 bytes `13 05 00 00 93 05 10 00`, last on byte 8 -> two writes: addr 0 data `0x00000513`, addr 4 data `0x00100593`, strb `4'hF` each; `core_rst` falls 3 cycles after the last handshake; `done=1`.
- Stream 6 bytes `01 02 03 04 05 06` -> second write at addr 4, data `0x00000605`, strb `4'b0011`.
- `in_valid` toggling every other cycle over 4 bytes -> exactly one write, same data as the back-to-back case; no write while idle.
- `MEM_BYTES=8`, stream 9 bytes -> two full writes, then `err=1` at the 9th handshake, no third write, `core_rst` held at 1.
- Assert `rst` low after 3 bytes, then reload 4 bytes `AA BB CC DD` -> a single write at addr 0 with data `0xDDCCBBAA`; the first 3 bytes never appear.
- With `PROG_LOADER_CHECKSUM_EN`: bytes `01 02` (last), then checksum `FD` -> `done=1`. Checksum `00` -> `err=1`, `core_rst=1`.
